simple_full_adder: RTL and testbench



---
 rtl/simple_full_adder_pkg.sv | 7 +
 rtl/simple_full_adder_cell.sv | 22 ++
 rtl/simple_full_adder.sv | 84 ++++++++
 tb/tb_simple_full_adder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/simple_full_adder_pkg.sv
// Shared constants for the registered ripple-carry adder.
package simple_full_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1;
  localparam int unsigned MAX_WIDTH     = 64;

endpackage : simple_full_adder_pkg

// File: rtl/simple_full_adder_cell.sv
// One-bit combinational full adder used as a ripple-chain stage.
// Ports:
//   a, b   - operand bits
//   cin    - carry into this bit
//   sum_c  - a ^ b ^ cin
//   cout_c - carry into the next bit
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum_c,
  output logic cout_c
);

  logic prop_c;

  // Carry propagates only when exactly one operand bit is set.
  assign prop_c = a ^ b;
  assign sum_c  = prop_c ^ cin;
  assign cout_c = (a & b) | (cin & prop_c);

endmodule : full_adder_cell

// File: rtl/simple_full_adder.sv
// Ripple-carry adder computing {cout, sum} = a + b + cin, with an optional
// output register (REG_OUT=1, latency 1) or a pure combinational path
// (REG_OUT=0, latency 0).
// Ports:
//   clk, rst_n - rising-edge clock, async active-low reset (registered mode)
//   in_valid   - qualifies a, b, cin
//   a, b, cin  - operands and carry-in
//   out_valid  - sum/cout hold a new result
//   sum, cout  - (a + b + cin) mod 2^WIDTH and the carry out of the top bit
module simple_full_adder
  import simple_full_adder_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned W = WIDTH;

  typedef struct packed {
    logic         cout;
    logic [W-1:0] sum;
  } add_result_t;

  logic [W:0]   carry_c;
  logic [W-1:0] sum_chain_c;
  add_result_t  res_c;

  assign carry_c[0] = cin;

  // Ripple chain: bit i consumes carry i and produces carry i+1.
  for (genvar i = 0; i < int'(W); i++) begin : g_cell
    full_adder_cell u_cell (
      .a      (a[i]),
      .b      (b[i]),
      .cin    (carry_c[i]),
      .sum_c  (sum_chain_c[i]),
      .cout_c (carry_c[i+1])
    );
  end

  assign res_c = '{cout: carry_c[W], sum: sum_chain_c};

  if (REG_OUT) begin : g_reg
    add_result_t res_q;
    logic        valid_q;

    // Capture only on valid input so that idle-cycle operand values
    // (including X) never reach the held result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        res_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= in_valid;
        if (in_valid) begin
          res_q <= res_c;
        end
      end
    end

    assign out_valid = valid_q;
    assign sum       = res_q.sum;
    assign cout      = res_q.cout;
  end else begin : g_comb
    // Clock and reset have no role in the bypass configuration.
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst_n};

    assign out_valid = in_valid;
    assign sum       = res_c.sum;
    assign cout      = res_c.cout;
  end

endmodule : simple_full_adder

// File: tb/tb_simple_full_adder.sv
`timescale 1ns/1ps
module tb_simple_full_adder;

  logic clk;
  logic rst_n;

  // WIDTH=1 registered
  logic       v1, a1, b1, c1, ov1, s1, co1;
  // WIDTH=4 registered
  logic       v4, c4, ov4, co4;
  logic [3:0] a4, b4, s4;
  // WIDTH=8 combinational
  logic       vc, cc, ovc, coc;
  logic [7:0] ac, bc, sc;
  // WIDTH=8 registered
  logic       v8, c8, ov8, co8;
  logic [7:0] a8, b8, s8;

  int n_tests;
  int n_fail;

  simple_full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
    .out_valid(ov1), .sum(s1), .cout(co1));

  simple_full_adder #(.WIDTH(4), .REG_OUT(1'b1)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .cin(c4),
    .out_valid(ov4), .sum(s4), .cout(co4));

  simple_full_adder #(.WIDTH(8), .REG_OUT(1'b0)) u_w8c (
    .clk(clk), .rst_n(rst_n), .in_valid(vc), .a(ac), .b(bc), .cin(cc),
    .out_valid(ovc), .sum(sc), .cout(coc));

  simple_full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
    .out_valid(ov8), .sum(s8), .cout(co8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Directed WIDTH=8 vectors: {a, b, cin, expected {cout,sum}}
  logic [7:0] t8_a   [6] = '{8'h80, 8'hFF, 8'h00, 8'h55, 8'h12, 8'h7F};
  logic [7:0] t8_b   [6] = '{8'h80, 8'hFF, 8'h00, 8'hAA, 8'h34, 8'h01};
  logic       t8_c   [6] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0};
  logic [8:0] t8_exp [6] = '{9'h100, 9'h1FF, 9'h000, 9'h100, 9'h046, 9'h080};

  // WIDTH=1 truth table indexed by {a,b,cin}
  logic [1:0] t1_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] rexp;
    logic [2:0] vec;

    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    {v1, a1, b1, c1} = '0;
    {v4, a4, b4, c4} = '0;
    {vc, ac, bc, cc} = '0;
    {v8, a8, b8, c8} = '0;

    // Reset state before any clock edge
    #2;
    check("rst_w1", {ov1, co1, s1}, 3'b000);
    check("rst_w4", {ov4, co4, s4}, 6'h00);
    check("rst_w8", {ov8, co8, s8}, 10'h000);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: WIDTH=1 exhaustive, back-to-back
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vec = 3'(i);
      {a1, b1, c1} = vec;
      v1 = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("w1_sum_%0d", i), {co1, s1}, t1_exp[i]);
      check($sformatf("w1_vld_%0d", i), ov1, 1'b1);
    end
    @(negedge clk);
    v1 = 1'b0;

    // 2: WIDTH=4 carry propagation
    a4 = 4'hF; b4 = 4'h0; c4 = 1'b1; v4 = 1'b1;
    @(posedge clk); #1;
    check("w4_F_0_1", {co4, s4}, 5'h10);
    @(negedge clk);
    a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    @(posedge clk); #1;
    check("w4_F_F_1", {co4, s4}, 5'h1F);

    // 3: single valid then hold for 3 idle cycles with changing operands
    @(negedge clk);
    a4 = 4'h5; b4 = 4'h3; c4 = 1'b0; v4 = 1'b1;
    @(posedge clk); #1;
    check("w4_hold_cap", {co4, s4}, 5'h08);
    check("w4_hold_vld", ov4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      v4 = 1'b0;
      a4 = 4'(4'hA + i); b4 = 4'hC; c4 = 1'b1;
      if (i == 1) begin
        a4 = 4'bx; b4 = 4'bx; c4 = 1'bx;
      end
      @(posedge clk); #1;
      check($sformatf("w4_hold_%0d", i), {co4, s4}, 5'h08);
      check($sformatf("w4_idle_vld_%0d", i), ov4, 1'b0);
    end

    // 4: reset mid-stream discards result at once
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
    @(posedge clk); #1;
    check("w1_pre_rst", {ov1, co1, s1}, 3'b111);
    #2;
    rst_n = 1'b0;
    #1;
    check("w1_rst_async", {ov1, co1, s1}, 3'b000);
    @(posedge clk); #1;
    check("w1_rst_held", {ov1, co1, s1}, 3'b000);
    @(negedge clk);
    v1 = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check($sformatf("w1_post_rst_%0d", i), {ov1, co1, s1}, 3'b000);
    end

    // 5: combinational WIDTH=8, zero latency
    @(negedge clk);
    ac = 8'h80; bc = 8'h80; cc = 1'b0; vc = 1'b1;
    #1;
    check("w8c_80_80", {coc, sc}, 9'h100);
    check("w8c_vld_hi", ovc, 1'b1);
    vc = 1'b0;
    #1;
    check("w8c_vld_lo", ovc, 1'b0);
    ac = 8'h0F; bc = 8'hF0; cc = 1'b1;
    #1;
    check("w8c_cin_prop", {coc, sc}, 9'h100);
    ac = 8'h00; bc = 8'h00; cc = 1'b0;
    #1;
    check("w8c_zero", {coc, sc}, 9'h000);
    ac = 8'hFF; bc = 8'hFF; cc = 1'b1;
    #1;
    check("w8c_ones", {coc, sc}, 9'h1FF);

    // 6a: registered WIDTH=8 directed, back-to-back
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a8 = t8_a[i]; b8 = t8_b[i]; c8 = t8_c[i]; v8 = 1'b1;
      @(posedge clk); #1;
      check($sformatf("w8_dir_%0d", i), {co8, s8}, t8_exp[i]);
      check($sformatf("w8_dir_vld_%0d", i), ov8, 1'b1);
    end

    // 6b: registered WIDTH=8 random against a 9-bit reference sum
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      a8 = ra; b8 = rb; c8 = rc; v8 = 1'b1;
      rexp = 9'(ra) + 9'(rb) + 9'(rc);
      @(posedge clk); #1;
      check($sformatf("w8_rnd_%0d", i), {co8, s8}, rexp);
    end
    @(negedge clk);
    v8 = 1'b0;
    @(posedge clk); #1;
    check("w8_vld_drop", ov8, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_simple_full_adder
